// File: rtl/sram_ctrl_fsm.sv
// Request/done front-end with SETUP/ACCESS/HOLD strobe sequencing for an asynchronous SRAM.
// Optional byte lanes: define SRAM_BYTE_LANE_EN to add the be[1:0] port (requires DW=16).
//
//  state  | meaning
//  IDLE   | ready for a request, chip deselected, bus released
//  SETUP  | address/CE_n asserted, write data driven, wait counter loaded
//  ACCESS | WE_n or OE_n low for WAIT_CYCLES cycles
//  HOLD   | strobes released, address/data held, done pulses
module sram_ctrl_fsm #(
  parameter int AW          = 18,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
`ifdef SRAM_BYTE_LANE_EN
  input  logic [1:0]    be,
`endif
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          done,
  inout  wire  [DW-1:0] SRAM_Data,
  output logic [AW-1:0] SRAM_Address,
  output logic          SRAM_WE_n,
  output logic          SRAM_OE_n,
  output logic          SRAM_CE_n,
  output logic          SRAM_UB_n,
  output logic          SRAM_LB_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_chk
    $error("sram_ctrl_fsm: WAIT_CYCLES must be in 1..15");
  end

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] addr_d;
  logic          accept, lanes_on, rd_cap, drv_q;
  logic          ce_n_d, we_n_d, oe_n_d, ub_n_d, lb_n_d;
`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]    be_q, be_d;

  if (DW != 16) begin : g_dw_chk
    $error("sram_ctrl_fsm: byte lanes require DW=16");
  end
`endif

  assign accept = (state_q == IDLE) && req;
  assign rd_cap = (state_q == ACCESS) && (cnt_q == 4'd0) && !we_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (req) state_d = SETUP;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_LOAD;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values are derived from the next state so every pin comes straight off a flop.
  always_comb begin
    we_d    = accept ? we    : we_q;
    wdata_d = accept ? wdata : wdata_q;
    addr_d  = accept ? addr  : SRAM_Address;
    ce_n_d  = (state_d == IDLE);
`ifdef SRAM_BYTE_LANE_EN
    be_d     = accept ? be : be_q;
    lanes_on = |be_d;
    ub_n_d   = ce_n_d | ~be_d[1];
    lb_n_d   = ce_n_d | ~be_d[0];
`else
    lanes_on = 1'b1;
    ub_n_d   = ce_n_d;
    lb_n_d   = ce_n_d;
`endif
    we_n_d = !((state_d == ACCESS) && we_d && lanes_on);
    oe_n_d = !((state_d == ACCESS) && !we_d && lanes_on);
  end

  // wdata_q needs no reset: it only reaches the bus while drv_q is set.
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      ready        <= 1'b1;
      done         <= 1'b0;
      rdata        <= '0;
      SRAM_Address <= '0;
      SRAM_WE_n    <= 1'b1;
      SRAM_OE_n    <= 1'b1;
      SRAM_CE_n    <= 1'b1;
      SRAM_UB_n    <= 1'b1;
      SRAM_LB_n    <= 1'b1;
      drv_q        <= 1'b0;
`ifdef SRAM_BYTE_LANE_EN
      be_q         <= 2'b00;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      ready        <= (state_d == IDLE);
      done         <= (state_d == HOLD);
      SRAM_Address <= addr_d;
      SRAM_WE_n    <= we_n_d;
      SRAM_OE_n    <= oe_n_d;
      SRAM_CE_n    <= ce_n_d;
      SRAM_UB_n    <= ub_n_d;
      SRAM_LB_n    <= lb_n_d;
      drv_q        <= (state_d != IDLE) && we_d;
`ifdef SRAM_BYTE_LANE_EN
      be_q         <= be_d;
      if (rd_cap) begin
        if (be_q[0]) rdata[7:0]    <= SRAM_Data[7:0];
        if (be_q[1]) rdata[DW-1:8] <= SRAM_Data[DW-1:8];
      end
`else
      if (rd_cap) rdata <= SRAM_Data;
`endif
    end
  end

  assign SRAM_Data = drv_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_fsm.sv
// Scoreboard bench for sram_ctrl_fsm with a small behavioural SRAM on the data bus.
// Byte-lane cases are compiled in when SRAM_BYTE_LANE_EN is defined.
module tb_sram_ctrl_fsm;

  localparam int W = 2;

  typedef struct {
    int          cyc;
    logic [15:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [17:0] addr;
  logic [15:0] wdata, rdata;
  logic        ready, done;
  wire  [15:0] sram_data;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]  be;
`endif

  int   n_chk = 0, n_fail = 0, n_done = 0, n_exp = 0, cyc = 0, last_acc = 0;
  exp_t sb[$];
  logic [15:0] rd_model = 16'h0;
  logic [15:0] exp_mem [256];
  logic [15:0] mem [256];
  logic        mem_boot;
  logic        mdl_drv;
  logic [15:0] mdl_q;

  sram_ctrl_fsm #(.AW(18), .DW(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef SRAM_BYTE_LANE_EN
    .be(be),
`endif
    .rdata(rdata), .ready(ready), .done(done), .SRAM_Data(sram_data),
    .SRAM_Address(sram_addr), .SRAM_WE_n(we_n), .SRAM_OE_n(oe_n),
    .SRAM_CE_n(ce_n), .SRAM_UB_n(ub_n), .SRAM_LB_n(lb_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(int i);
    if (i == 255) return 16'hC0DE;
    if (i == 128) return 16'hABCD;
    return 16'(i * 257);
  endfunction

  // Behavioural SRAM: drives the full word whenever output-enabled, writes enabled lanes.
  assign mdl_drv   = !ce_n && !oe_n && we_n;
  assign mdl_q     = mem[sram_addr[7:0]];
  assign sram_data = mdl_drv ? mdl_q : 16'hzzzz;

  always @(posedge clk) begin
    if (mem_boot) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_data[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_data[15:8];
    end
  end

  function automatic logic [15:0] bus_obs();
    return (^sram_data === 1'bx) ? 16'h0 : sram_data;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done) begin
      n_done++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_latency", cyc, e.cyc);
        chk("rdata", rdata, e.rd);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!ready) chk("idle_timeout", 0, 1);
  endtask

  // Called at a negedge; returns at the negedge of the SETUP cycle.
  task automatic issue(input logic w, input logic [17:0] a, input logic [15:0] d, input logic [1:0] b);
    logic [15:0] nv;
    int t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    req = 1'b1; we = w; addr = a; wdata = d;
`ifdef SRAM_BYTE_LANE_EN
    be = b;
`endif
    last_acc = cyc;
    if (w) begin
      if (b[0]) exp_mem[a[7:0]][7:0]  = d[7:0];
      if (b[1]) exp_mem[a[7:0]][15:8] = d[15:8];
    end else begin
      nv = rd_model;
      if (b[0]) nv[7:0]  = exp_mem[a[7:0]][7:0];
      if (b[1]) nv[15:8] = exp_mem[a[7:0]][15:8];
      rd_model = nv;
    end
    sb.push_back('{last_acc + W + 2, rd_model});
    n_exp++;
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = 18'($urandom); wdata = 16'($urandom);
  endtask

  // Bit i of each mask is the expectation i cycles after SETUP began.
  task automatic trace(input string nm, input logic [17:0] a, input logic [4:0] wn, input logic [4:0] on,
                       input logic [4:0] cn, input logic [4:0] dn, input logic [4:0] bm, input logic [15:0] v);
    for (int i = 0; i < 5; i++) begin
      chk({nm, "_we_n"}, we_n, wn[i]);
      chk({nm, "_oe_n"}, oe_n, on[i]);
      chk({nm, "_ce_n"}, ce_n, cn[i]);
      chk({nm, "_ub_n"}, ub_n, cn[i]);
      chk({nm, "_lb_n"}, lb_n, cn[i]);
      chk({nm, "_ready"}, ready, cn[i]);
      chk({nm, "_done"}, done, dn[i]);
      chk({nm, "_bus"}, bus_obs(), bm[i] ? v : 16'h0);
      if (i < 4) begin
        chk({nm, "_addr"}, sram_addr, a);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, a1;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; mem_boot = 1'b1;
`ifdef SRAM_BYTE_LANE_EN
    be = 2'b11;
`endif
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    repeat (2) @(negedge clk);
    rst = 1'b0; mem_boot = 1'b0;

    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_ub_lb", {ub_n, lb_n}, 2'b11);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus", bus_obs(), 0);

    issue(1'b1, 18'h00123, 16'hBEEF, 2'b11);
    trace("wr", 18'h00123, 5'b11001, 5'b11111, 5'b10000, 5'b01000, 5'b01111, 16'hBEEF);

    issue(1'b0, 18'h00123, 16'h0F0F, 2'b11);
    trace("rd", 18'h00123, 5'b11111, 5'b11001, 5'b10000, 5'b01000, 5'b00110, 16'hBEEF);
    chk("rd_hold", rdata, 16'hBEEF);

    n0 = n_done;
    issue(1'b1, 18'h00040, 16'h5555, 2'b11);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 18'h3FFFF; wdata = 16'h1111;
    @(negedge clk);
    req = 1'b0;
    chk("busy_addr", sram_addr, 18'h00040);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("busy_one_done", n_done - n0, 1);
    issue(1'b0, 18'h3FFFF, 16'h0, 2'b11);
    wait_idle();
    issue(1'b0, 18'h00040, 16'h0, 2'b11);
    wait_idle();
    issue(1'b1, 18'h00050, 16'h7777, 2'b11);
    wait_idle();
    chk("wr_keeps_rdata", rdata, 16'h5555);

    issue(1'b0, 18'h00050, 16'h0, 2'b11);
    a1 = last_acc;
    issue(1'b0, 18'h00123, 16'h0, 2'b11);
    chk("throughput", last_acc - a1, W + 3);
    wait_idle();

    issue(1'b1, 18'h00060, 16'h9999, 2'b11);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    n_exp--;
    @(negedge clk);
    rst = 1'b0;
    rd_model = 16'h0;
    chk("midrst_we_n", we_n, 1);
    chk("midrst_ce_n", ce_n, 1);
    chk("midrst_bus", bus_obs(), 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_rdata", rdata, 0);
    repeat (4) @(negedge clk);
    issue(1'b0, 18'h00050, 16'h0, 2'b11);
    wait_idle();

`ifdef SRAM_BYTE_LANE_EN
    issue(1'b1, 18'h00070, 16'h1234, 2'b11);
    wait_idle();
    issue(1'b0, 18'h00070, 16'h0, 2'b11);
    wait_idle();
    issue(1'b0, 18'h00080, 16'h0, 2'b01);
    @(negedge clk);
    chk("lane_ub_n", ub_n, 1);
    chk("lane_lb_n", lb_n, 0);
    chk("lane_oe_n", oe_n, 0);
    wait_idle();
    chk("lane_merge", rdata, 16'h12CD);
    n0 = n_done;
    issue(1'b0, 18'h00080, 16'h0, 2'b00);
    repeat (3) begin
      @(negedge clk);
      chk("be0_oe_n", oe_n, 1);
      chk("be0_we_n", we_n, 1);
    end
    wait_idle();
    chk("be0_done", n_done - n0, 1);
`endif

    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("done_count", n_done, n_exp);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl_fsm.md
Name: sram_ctrl_fsm

Overview:
- Parametrised, fully synchronous controller for an asynchronous SRAM, such as the 256K x 16 board SRAM.
- Sits between the memory-stage unit and the SRAM pins.
- Front-end: single-request handshake (ready/req, done pulse).
- Back-end: SETUP / ACCESS / HOLD strobe sequencing, with a programmable number of access wait cycles for both reads and writes.

Parameters:
- AW, 18, SRAM address width.
- DW, 16, SRAM data width. Must be 16 when SRAM_BYTE_LANE_EN is defined.
- WAIT_CYCLES, 2, number of cycles the WE_n/OE_n strobe is held low. Legal range is 1..15. A value of 0 is a configuration error, flagged by a simulation-only check.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  request; sampled only while ready=1.
- we  in  1  1=write, 0=read; qualified by req.
- addr  in  AW  request address.
- wdata  in  DW  write data.
- rdata  out  DW  read data; holds its value until the next read completes.
- ready  out  1  controller idle, can accept req.
- done  out  1  one-cycle completion pulse, for reads and writes.
- SRAM_Data  inout  DW  SRAM data bus.
- SRAM_Address  out  AW  SRAM address.
- SRAM_WE_n  out  1  write enable, active-low.
- SRAM_OE_n  out  1  output enable, active-low.
- SRAM_CE_n  out  1  chip enable, active-low.
- SRAM_UB_n  out  1  upper byte enable, active-low.
- SRAM_LB_n  out  1  lower byte enable, active-low.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - Every SRAM pin output is registered; no combinational path from req to the pins.
- Reset values:
  - State IDLE, ready=1, done=0, rdata=0, SRAM_Address=0.
  - SRAM_WE_n=1, SRAM_OE_n=1, SRAM_CE_n=1, SRAM_UB_n=1, SRAM_LB_n=1.
  - SRAM_Data=Z, wait counter=0.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - ready=1, CE_n=1, bus released.
  - On req=1, latch addr, wdata and we. Next state SETUP, ready=0.
- SETUP (1 cycle):
  - CE_n=0; address driven from the latch; UB_n=LB_n=0.
  - WE_n=1 and OE_n=1.
  - Write: drive SRAM_Data from the wdata latch.
  - Load counter with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles):
  - Write: WE_n=0, data driven.
  - Read: OE_n=0, bus Z.
  - Counter decrements each cycle; exit to HOLD when counter=0.
  - Read: register SRAM_Data into rdata on the last ACCESS edge.
- HOLD (1 cycle):
  - WE_n=1, OE_n=1, CE_n=0, address unchanged.
  - Write data stays driven this cycle (hold time).
  - done=1 for this cycle only. Next state IDLE.
- Latency: request accepted at edge N → done high in cycle N+WAIT_CYCLES+2 → ready=1 in the following cycle. Throughput is one access per WAIT_CYCLES+3 cycles.
- Busy handling: req while ready=0 is ignored and not queued. Inputs may change freely while busy; only the latched copies are used.
- Write bus release: SRAM_Data is never driven outside SETUP/ACCESS/HOLD of a write. Release happens on the edge leaving HOLD.
- Read data integrity: rdata is only updated by reads; writes leave it unchanged.
- Reset mid-operation (any state): return to IDLE on the reset edge.
  - All strobes deassert, bus goes to Z, rdata=0.
  - No done pulse; the in-flight access is dropped.
- Addresses are AW bits and wrap naturally; no range checking.

Optional Feature:
- Macro SRAM_BYTE_LANE_EN.
- Defined:
  - Adds input be[1:0], latched with the request.
  - SRAM_UB_n=~be[1] and SRAM_LB_n=~be[0] during SETUP/ACCESS/HOLD.
  - Read: rdata lanes with be bit 0 keep their previous value.
  - be=2'b00: access runs its full timing with WE_n/OE_n held at 1. done still pulses; rdata is unchanged.
- Not defined:
  - No be port.
  - UB_n=LB_n=CE_n (both lanes enabled whenever the chip is selected).

Test Plan:
- Reset then idle: hold rst 2 cycles → ready=1, done=0, CE_n=WE_n=OE_n=1, SRAM_Data=Z, rdata=0.
- Write: WAIT_CYCLES=2, req/we=1, addr=18'h00123, wdata=16'hBEEF.
  - SETUP 1 cycle with WE_n=1.
  - WE_n=0 for exactly 2 cycles with bus=16'hBEEF.
  - HOLD with done=1 and bus still driven; ready=1 the next cycle.
- Read back: SRAM model returns 16'hBEEF at 18'h00123 → OE_n=0 for 2 cycles; done high at accept+4; rdata=16'hBEEF; bus never driven by the DUT.
- Busy ignore: second req (addr 18'h3FFFF) during ACCESS → no extra access; exactly one done pulse.
- Reset mid-access: assert rst in the 2nd ACCESS cycle of a write → next cycle WE_n=1, CE_n=1, bus=Z, no done.
- With SRAM_BYTE_LANE_EN: read with be=2'b01 after rdata=16'h1234, SRAM holds 16'hABCD → UB_n=1, LB_n=0; rdata=16'h12CD. Request with be=2'b00 → WE_n/OE_n stay 1; done still pulses.
